// File: rtl/ysyx_041461_trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_041461_trap_ctrl_pkg
//  Description : Trap codes, mcause constants and FSM state encoding shared
//                by the trap controller and its priority encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package ysyx_041461_trap_ctrl_pkg;

    localparam logic [3:0] c_TRAP_NOP       = 4'd0;
    localparam logic [3:0] c_TRAP_IF_MIS    = 4'd1;
    localparam logic [3:0] c_TRAP_ECALL     = 4'd2;
    localparam logic [3:0] c_TRAP_MRET      = 4'd3;
    localparam logic [3:0] c_TRAP_EBREAK    = 4'd4;
    localparam logic [3:0] c_TRAP_ILLEGAL   = 4'd5;
    localparam logic [3:0] c_TRAP_LD_MIS    = 4'd6;
    localparam logic [3:0] c_TRAP_ST_MIS    = 4'd7;

    localparam int c_CAUSE_IF_MIS  = 0;
    localparam int c_CAUSE_ILLEGAL = 2;
    localparam int c_CAUSE_EBREAK  = 3;
    localparam int c_CAUSE_LD_MIS  = 4;
    localparam int c_CAUSE_ST_MIS  = 6;
    localparam int c_CAUSE_ECALL   = 11;
    localparam int c_CAUSE_TIMER   = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_041461_trap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_041461_trap_ctrl_if
//  Description : WB/CSR/IF-redirect signal bundle of the trap controller.
//                slave = trap controller, master = surrounding pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
interface ysyx_041461_trap_ctrl_if #(
    parameter int XLEN   = 64,
    parameter int TRAP_W = 4
) ();
    logic              wb_valid;
    logic [TRAP_W-1:0] wb_trap;
    logic [XLEN-1:0]   wb_pc;
    logic              mstatus_mie;
    logic              mie_mtie;
    logic              mip_mtip;
    logic [XLEN-1:0]   mtvec;
    logic [XLEN-1:0]   mepc;
    logic              redir_ready;
    logic              redir_valid;
    logic [XLEN-1:0]   redir_pc;
    logic              flush;
    logic              wb_stall;
    logic              csr_commit;
    logic              csr_is_mret;
    logic [XLEN-1:0]   csr_cause;
    logic [XLEN-1:0]   csr_epc;
    logic              busy;

    modport master (
        output wb_valid, wb_trap, wb_pc, mstatus_mie, mie_mtie, mip_mtip,
               mtvec, mepc, redir_ready,
        input  redir_valid, redir_pc, flush, wb_stall, csr_commit,
               csr_is_mret, csr_cause, csr_epc, busy
    );

    modport slave (
        input  wb_valid, wb_trap, wb_pc, mstatus_mie, mie_mtie, mip_mtip,
               mtvec, mepc, redir_ready,
        output redir_valid, redir_pc, flush, wb_stall, csr_commit,
               csr_is_mret, csr_cause, csr_epc, busy
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_041461_trap_ctrl_trap_prio.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_041461_trap_ctrl_trap_prio
//  Description : Combinational priority encoder: exception/MRET over timer
//                interrupt, producing event, mcause, redirect target, is_mret.
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_041461_trap_ctrl_trap_prio
    import ysyx_041461_trap_ctrl_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int TRAP_W = 4,
    parameter bit VEC_EN = 1'b1
) (
    input  wire logic [TRAP_W-1:0] trap,
    input  wire logic              irq_pend,
    input  wire logic [XLEN-1:0]   mtvec,
    input  wire logic [XLEN-1:0]   mepc,
    output logic                   take,
    output logic                   is_mret,
    output logic [XLEN-1:0]        cause,
    output logic [XLEN-1:0]        target
);

    logic            w_exc;
    logic [XLEN-1:0] w_base;

    always_comb begin
        w_exc   = 1'b1;
        is_mret = 1'b0;
        cause   = '0;
        w_base  = {mtvec[XLEN-1:2], 2'b00};
        target  = w_base;
        case (trap)
            TRAP_W'(c_TRAP_IF_MIS):  cause = XLEN'(c_CAUSE_IF_MIS);
            TRAP_W'(c_TRAP_ECALL):   cause = XLEN'(c_CAUSE_ECALL);
            TRAP_W'(c_TRAP_MRET):    is_mret = 1'b1;
            TRAP_W'(c_TRAP_EBREAK):  cause = XLEN'(c_CAUSE_EBREAK);
            TRAP_W'(c_TRAP_ILLEGAL): cause = XLEN'(c_CAUSE_ILLEGAL);
            TRAP_W'(c_TRAP_LD_MIS):  cause = XLEN'(c_CAUSE_LD_MIS);
            TRAP_W'(c_TRAP_ST_MIS):  cause = XLEN'(c_CAUSE_ST_MIS);
            default:                 w_exc = 1'b0;
        endcase
        if (is_mret) begin
            target = mepc;
        end else if (!w_exc && irq_pend) begin
            cause = {1'b1, (XLEN-1)'(c_CAUSE_TIMER)};
            // Vectored mode only applies to interrupts; exceptions go to BASE.
            if (VEC_EN && mtvec[1:0] == 2'b01)
                target = w_base + XLEN'(4 * c_CAUSE_TIMER);
        end
        take = w_exc | irq_pend;
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_041461_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_041461_trap_ctrl
//  Description : Trap entry / MRET sequencer: stalls WB, flushes the front
//                pipeline, pulses the CSR commit and redirects IF.
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_041461_trap_ctrl
    import ysyx_041461_trap_ctrl_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int TRAP_W = 4,
    parameter bit VEC_EN = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    ysyx_041461_trap_ctrl_if.slave bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_target;
    logic            r_is_mret;
    logic            r_first;

    logic            w_irq_pend;
    logic            w_take;
    logic            w_is_mret;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_target;
    logic            w_event;
    logic            w_busy;
    logic            w_flush;
    logic            w_stall;
    logic            w_redir_valid;
    logic            w_commit;

    assign w_irq_pend = bus.mstatus_mie & bus.mie_mtie & bus.mip_mtip;

    ysyx_041461_trap_ctrl_trap_prio #(
        .XLEN   (XLEN),
        .TRAP_W (TRAP_W),
        .VEC_EN (VEC_EN)
    ) u_prio (
        .trap     (bus.wb_trap),
        .irq_pend (w_irq_pend),
        .mtvec    (bus.mtvec),
        .mepc     (bus.mepc),
        .take     (w_take),
        .is_mret  (w_is_mret),
        .cause    (w_cause),
        .target   (w_target)
    );

    assign w_event = (r_state == ST_IDLE) & bus.wb_valid & w_take;
    assign w_busy  = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Everything the sequence needs is captured at the event cycle so later
    // CSR or interrupt changes cannot disturb a redirect in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause   <= '0;
            r_epc     <= '0;
            r_target  <= '0;
            r_is_mret <= 1'b0;
            r_first   <= 1'b0;
        end else if (w_event) begin
            r_cause   <= w_cause;
            r_epc     <= bus.wb_pc;
            r_target  <= w_target;
            r_is_mret <= w_is_mret;
            r_first   <= 1'b1;
        end else if (r_state == ST_REDIR) begin
            r_first   <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_flush       = 1'b0;
        w_stall       = 1'b0;
        w_redir_valid = 1'b0;
        w_commit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_event;
                if (w_event) w_state_nxt = ST_REDIR;
            end
            ST_REDIR: begin
                w_flush       = 1'b1;
                w_stall       = 1'b1;
                w_redir_valid = 1'b1;
                w_commit      = r_first;
                if (bus.redir_ready) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_flush     = 1'b1;
                w_stall     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.redir_valid = w_redir_valid;
    assign bus.redir_pc    = w_redir_valid ? r_target : '0;
    assign bus.flush       = w_flush;
    assign bus.wb_stall    = w_stall;
    assign bus.csr_commit  = w_commit;
    assign bus.csr_is_mret = w_commit & r_is_mret;
    assign bus.csr_cause   = w_busy ? r_cause : '0;
    assign bus.csr_epc     = w_busy ? r_epc : '0;
    assign bus.busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_041461_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_041461_trap_ctrl
//  Description : Directed self-checking bench for the trap controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ysyx_041461_trap_ctrl;

    localparam int c_XLEN = 64;
    localparam logic [63:0] c_TIMER = {1'b1, 63'd7};

    typedef struct {
        logic        valid;
        logic [3:0]  trap;
        logic [2:0]  irq;      // {mstatus_mie, mie_mtie, mip_mtip}
        logic [63:0] pc;
        logic [63:0] mtvec;
        logic [63:0] mepc;
        logic        ev;
        logic [63:0] cause;
        logic [63:0] target;
        logic        mret;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[13];

    ysyx_041461_trap_ctrl_if #(.XLEN(c_XLEN), .TRAP_W(4)) bus ();

    ysyx_041461_trap_ctrl #(.XLEN(c_XLEN), .TRAP_W(4), .VEC_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"},   64'(bus.busy), 64'd0);
        chk({tag, " rvalid"}, 64'(bus.redir_valid), 64'd0);
        chk({tag, " flush"},  64'(bus.flush), 64'd0);
        chk({tag, " commit"}, 64'(bus.csr_commit), 64'd0);
        chk({tag, " cause"},  bus.csr_cause, 64'd0);
        chk({tag, " epc"},    bus.csr_epc, 64'd0);
        chk({tag, " rpc"},    bus.redir_pc, 64'd0);
    endtask

    task automatic drive(input logic v, input logic [3:0] t, input logic [63:0] pc);
        bus.wb_valid = v;
        bus.wb_trap  = t;
        bus.wb_pc    = pc;
    endtask

    task automatic set_irq(input logic [2:0] b);
        {bus.mstatus_mie, bus.mie_mtie, bus.mip_mtip} = b;
    endtask

    initial begin
        //             valid trap   irq     pc              mtvec           mepc            ev    cause    target          mret
        vecs[0]  = '{1'b1, 4'd2, 3'b000, 64'h8000_0010, 64'h8000_1000, 64'h0,          1'b1, 64'd11,  64'h8000_1000, 1'b0};
        vecs[1]  = '{1'b1, 4'd3, 3'b000, 64'h8000_0030, 64'h8000_1000, 64'h8000_0044, 1'b1, 64'd0,   64'h8000_0044, 1'b1};
        vecs[2]  = '{1'b1, 4'd0, 3'b111, 64'h8000_0020, 64'h8000_1001, 64'h0,          1'b1, c_TIMER, 64'h8000_101C, 1'b0};
        vecs[3]  = '{1'b1, 4'd5, 3'b111, 64'h8000_0024, 64'h8000_1001, 64'h0,          1'b1, 64'd2,   64'h8000_1000, 1'b0};
        vecs[4]  = '{1'b1, 4'd4, 3'b000, 64'h8000_0028, 64'h8000_2000, 64'h0,          1'b1, 64'd3,   64'h8000_2000, 1'b0};
        vecs[5]  = '{1'b1, 4'd6, 3'b000, 64'h8000_002C, 64'h8000_2003, 64'h0,          1'b1, 64'd4,   64'h8000_2000, 1'b0};
        vecs[6]  = '{1'b1, 4'd7, 3'b000, 64'h8000_0034, 64'h8000_2000, 64'h0,          1'b1, 64'd6,   64'h8000_2000, 1'b0};
        vecs[7]  = '{1'b1, 4'd1, 3'b000, 64'h8000_0038, 64'h8000_2000, 64'h0,          1'b1, 64'd0,   64'h8000_2000, 1'b0};
        vecs[8]  = '{1'b1, 4'd9, 3'b000, 64'h8000_003C, 64'h8000_2000, 64'h0,          1'b0, 64'd0,   64'h0,          1'b0};
        vecs[9]  = '{1'b1, 4'd0, 3'b011, 64'h8000_0040, 64'h8000_2000, 64'h0,          1'b0, 64'd0,   64'h0,          1'b0};
        vecs[10] = '{1'b1, 4'd0, 3'b111, 64'h8000_0048, 64'h8000_1002, 64'h0,          1'b1, c_TIMER, 64'h8000_1000, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 3'b111, 64'h8000_004C, 64'h8000_1001, 64'h0,          1'b0, 64'd0,   64'h0,          1'b0};
        vecs[12] = '{1'b1, 4'd0, 3'b101, 64'h8000_0050, 64'h8000_1001, 64'h0,          1'b0, 64'd0,   64'h0,          1'b0};

        drive(1'b0, 4'd0, 64'h0);
        set_irq(3'b000);
        bus.mtvec = '0;
        bus.mepc = '0;
        bus.redir_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset stall", 64'(bus.wb_stall), 64'd0);

        // Table-driven single events with IF ready immediately
        for (int i = 0; i < 13; i++) begin
            cyc();
            drive(vecs[i].valid, vecs[i].trap, vecs[i].pc);
            set_irq(vecs[i].irq);
            bus.mtvec = vecs[i].mtvec;
            bus.mepc = vecs[i].mepc;
            bus.redir_ready = 1'b1;
            #1;
            chk($sformatf("v%0d N stall", i), 64'(bus.wb_stall), 64'(vecs[i].ev));
            chk($sformatf("v%0d N busy", i), 64'(bus.busy), 64'd0);
            cyc();
            drive(1'b0, 4'd0, 64'h0);
            set_irq(3'b000);
            bus.mtvec = 64'hDEAD_0000;
            bus.mepc = 64'hBEEF_0000;
            #1;
            if (vecs[i].ev) begin
                chk($sformatf("v%0d R rvalid", i), 64'(bus.redir_valid), 64'd1);
                chk($sformatf("v%0d R rpc", i), bus.redir_pc, vecs[i].target);
                chk($sformatf("v%0d R cause", i), bus.csr_cause, vecs[i].cause);
                chk($sformatf("v%0d R epc", i), bus.csr_epc, vecs[i].pc);
                chk($sformatf("v%0d R commit", i), 64'(bus.csr_commit), 64'd1);
                chk($sformatf("v%0d R mret", i), 64'(bus.csr_is_mret), 64'(vecs[i].mret));
                chk($sformatf("v%0d R flush", i), 64'(bus.flush), 64'd1);
                chk($sformatf("v%0d R stall", i), 64'(bus.wb_stall), 64'd1);
                cyc();
                chk($sformatf("v%0d D rvalid", i), 64'(bus.redir_valid), 64'd0);
                chk($sformatf("v%0d D flush", i), 64'(bus.flush), 64'd1);
                chk($sformatf("v%0d D stall", i), 64'(bus.wb_stall), 64'd1);
                chk($sformatf("v%0d D commit", i), 64'(bus.csr_commit), 64'd0);
                chk($sformatf("v%0d D busy", i), 64'(bus.busy), 64'd1);
                cyc();
            end
            chk_idle($sformatf("v%0d end", i));
        end

        // MRET with IF not ready for 3 cycles; a second trap during REDIR is ignored
        cyc();
        drive(1'b1, 4'd3, 64'h8000_0060);
        bus.mepc = 64'h8000_0044;
        bus.redir_ready = 1'b0;
        #1;
        chk("mret N stall", 64'(bus.wb_stall), 64'd1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 1) drive(1'b1, 4'd4, 64'h8000_0070);
            else        drive(1'b0, 4'd0, 64'h0);
            bus.mepc = 64'h1111_0000 + 64'(k);
            if (k == 3) bus.redir_ready = 1'b1;
            #1;
            chk($sformatf("mret k%0d rvalid", k), 64'(bus.redir_valid), 64'd1);
            chk($sformatf("mret k%0d rpc", k), bus.redir_pc, 64'h8000_0044);
            chk($sformatf("mret k%0d commit", k), 64'(bus.csr_commit), 64'(k == 0));
            chk($sformatf("mret k%0d ismret", k), 64'(bus.csr_is_mret), 64'(k == 0));
            chk($sformatf("mret k%0d flush", k), 64'(bus.flush), 64'd1);
            chk($sformatf("mret k%0d cause", k), bus.csr_cause, 64'd0);
        end
        cyc();
        chk("mret D rvalid", 64'(bus.redir_valid), 64'd0);
        chk("mret D flush", 64'(bus.flush), 64'd1);
        cyc();
        chk_idle("mret end");
        cyc();
        chk_idle("mret after");

        // ILLEGAL with simultaneous interrupt, then interrupt on next valid WB
        drive(1'b1, 4'd5, 64'h8000_0080);
        set_irq(3'b111);
        bus.mtvec = 64'h8000_1001;
        bus.redir_ready = 1'b1;
        cyc();
        drive(1'b0, 4'd0, 64'h0);
        #1;
        chk("s4 R cause", bus.csr_cause, 64'd2);
        chk("s4 R rpc", bus.redir_pc, 64'h8000_1000);
        cyc();
        cyc();
        chk("s4 idle busy", 64'(bus.busy), 64'd0);
        chk("s4 idle stall", 64'(bus.wb_stall), 64'd0);
        drive(1'b1, 4'd0, 64'h8000_0084);
        #1;
        chk("s4 irq stall", 64'(bus.wb_stall), 64'd1);
        cyc();
        drive(1'b0, 4'd0, 64'h0);
        #1;
        chk("s4 irq cause", bus.csr_cause, c_TIMER);
        chk("s4 irq epc", bus.csr_epc, 64'h8000_0084);
        chk("s4 irq rpc", bus.redir_pc, 64'h8000_101C);
        chk("s4 irq commit", 64'(bus.csr_commit), 64'd1);
        cyc();
        cyc();

        // Pending interrupt with no instruction in WB: no activity
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("s5 c%0d stall", k), 64'(bus.wb_stall), 64'd0);
            chk($sformatf("s5 c%0d busy", k), 64'(bus.busy), 64'd0);
            cyc();
        end
        set_irq(3'b000);

        // Reset while waiting in REDIR aborts the sequence
        drive(1'b1, 4'd2, 64'h8000_0090);
        bus.mtvec = 64'h8000_3000;
        bus.redir_ready = 1'b0;
        cyc();
        drive(1'b0, 4'd0, 64'h0);
        #1;
        chk("s6 R commit", 64'(bus.csr_commit), 64'd1);
        cyc();
        chk("s6 R2 rvalid", 64'(bus.redir_valid), 64'd1);
        chk("s6 R2 commit", 64'(bus.csr_commit), 64'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk_idle("s6 rst");
        chk("s6 rst stall", 64'(bus.wb_stall), 64'd0);
        bus.redir_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("s6 post%0d commit", k), 64'(bus.csr_commit), 64'd0);
            chk($sformatf("s6 post%0d busy", k), 64'(bus.busy), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
